ysyx_l1i_bus_bridge: RTL and testbench

//  Responder (slave) end of l1i_bus_if. Accepts one cache-line refill request from the L1I
//  and fetches the line over an AXI4 read-address/read-data master port. Returns LINE_WORDS
//  32-bit beats to the L1I with rlast on the final beat. Sits between the L1I and the SoC crossbar.

---
 rtl/ysyx_l1i_bus_bridge.sv | 151 +++++++++++++++
 tb/tb_ysyx_l1i_bus_bridge.sv | 505 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_l1i_bus_bridge.sv
// ysyx_l1i_bus_bridge
//   Responder end of the L1I refill bus. Accepts one line-refill request, fetches the
//   line over an AXI4 read-address/read-data master port and streams LINE_WORDS 32-bit
//   beats back to the L1I, flagging the final beat with bus_rlast.
//
//   Build option:
//     YSYX_L1I_BURST_EN  defined  : one INCR burst per line (arlen = LINE_WORDS-1).
//                        undefined: LINE_WORDS single-beat reads (arlen = 0), one AR each.
//
//   Ports:
//     clock, reset            clock, asynchronous active-low reset
//     bus_arvalid, bus_araddr refill request from L1I (held until accepted)
//     bus_rready              1-cycle accept pulse (only in idle)
//     bus_rdata/rvalid/rlast  returned words, passed through from AXI R with no added latency
//     axi_ar*                 AXI read address channel (master)
//     axi_r*                  AXI read data channel (master); axi_rlast is ignored
//     rerr                    sticky error for the current line, cleared on next accept
module ysyx_l1i_bus_bridge #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned LINE_WORDS = 4,
    parameter logic [3:0]  AXI_ID     = 4'd0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            bus_arvalid,
    input  logic [XLEN-1:0] bus_araddr,
    output logic            bus_rready,
    output logic [XLEN-1:0] bus_rdata,
    output logic            bus_rvalid,
    output logic            bus_rlast,
    output logic            axi_arvalid,
    input  logic            axi_arready,
    output logic [XLEN-1:0] axi_araddr,
    output logic [3:0]      axi_arid,
    output logic [7:0]      axi_arlen,
    output logic [2:0]      axi_arsize,
    output logic [1:0]      axi_arburst,
    input  logic            axi_rvalid,
    output logic            axi_rready,
    input  logic [XLEN-1:0] axi_rdata,
    input  logic [1:0]      axi_rresp,
    input  logic            axi_rlast,
    output logic            rerr
);

    localparam int unsigned CntW = $clog2(LINE_WORDS);
    localparam int unsigned OffW = CntW + 2;
    localparam logic [CntW-1:0] LastCnt = CntW'(LINE_WORDS - 1);
`ifdef YSYX_L1I_BURST_EN
    localparam logic [7:0] ArLen = 8'(LINE_WORDS - 1);
`else
    localparam logic [7:0] ArLen = 8'd0;
`endif

    typedef enum logic [1:0] {StIdle, StAr, StR} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] count_q, count_d;
    logic [XLEN-1:0] base_q, base_d;
    logic            rerr_q, rerr_d;

    logic            accept;
    logic            beat;
    logic            last_beat;
    logic            beat_err;
    logic [XLEN-1:0] word_offset;

    // Low address bits are implied by line alignment; AXI rlast is not used for framing.
    logic unused_inputs;
    assign unused_inputs = ^{bus_araddr[OffW-1:0], axi_rlast};

    // reset gates accept so bus_rready stays low while reset is asserted.
    assign accept      = reset & bus_arvalid & (state_q == StIdle);
    assign beat        = (state_q == StR) & axi_rvalid;
    assign last_beat   = beat & (count_q == LastCnt);
    assign beat_err    = beat & (axi_rresp != 2'b00);
    assign word_offset = {{(XLEN - OffW){1'b0}}, count_q, 2'b00};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            count_q <= '0;
            base_q  <= '0;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            base_q  <= base_d;
            rerr_q  <= rerr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        base_d  = base_q;
        rerr_d  = rerr_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    base_d  = {bus_araddr[XLEN-1:OffW], {OffW{1'b0}}};
                    count_d = '0;
                    rerr_d  = 1'b0;
                    state_d = StAr;
                end
            end
            StAr: begin
                if (axi_arready) begin
                    state_d = StR;
                end
            end
            StR: begin
                if (beat) begin
                    // Wraps to zero on the final beat.
                    count_d = count_q + 1'b1;
                    if (beat_err) begin
                        rerr_d = 1'b1;
                    end
                    if (last_beat) begin
                        state_d = StIdle;
                    end
`ifndef YSYX_L1I_BURST_EN
                    else begin
                        // Single-beat mode: issue the next word's read.
                        state_d = StAr;
                    end
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus_rready  = accept;
    assign bus_rvalid  = beat;
    assign bus_rdata   = beat ? axi_rdata : '0;
    assign bus_rlast   = last_beat;

    assign axi_arvalid = (state_q == StAr);
    // In burst mode count is still zero while in AR, so this is the line base.
    assign axi_araddr  = axi_arvalid ? (base_q + word_offset) : '0;
    assign axi_arlen   = axi_arvalid ? ArLen : 8'd0;
    assign axi_arid    = AXI_ID;
    assign axi_arsize  = 3'b010;
    assign axi_arburst = 2'b01;
    assign axi_rready  = (state_q == StR);

    // Error is visible with the failing beat; the accept cycle already reads clean.
    assign rerr        = ~accept & (rerr_q | beat_err);

endmodule

// File: tb/tb_ysyx_l1i_bus_bridge.sv
module tb_ysyx_l1i_bus_bridge;

    logic        clock;
    logic        reset;
    logic        bus_arvalid;
    logic [31:0] bus_araddr;
    logic        bus_rready;
    logic [31:0] bus_rdata;
    logic        bus_rvalid;
    logic        bus_rlast;
    logic        axi_arvalid;
    logic        axi_arready;
    logic [31:0] axi_araddr;
    logic [3:0]  axi_arid;
    logic [7:0]  axi_arlen;
    logic [2:0]  axi_arsize;
    logic [1:0]  axi_arburst;
    logic        axi_rvalid;
    logic        axi_rready;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rlast;
    logic        rerr;

`ifdef YSYX_L1I_BURST_EN
    localparam int unsigned ExpArs    = 1;
    localparam int unsigned ExpArStep = 0;
    localparam logic [7:0]  ExpLen    = 8'd3;
`else
    localparam int unsigned ExpArs    = 4;
    localparam int unsigned ExpArStep = 4;
    localparam logic [7:0]  ExpLen    = 8'd0;
`endif
    localparam logic [8:0] ExpAttr = {4'h0, 3'b010, 2'b01};

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;

    ysyx_l1i_bus_bridge #(
        .XLEN       (32),
        .LINE_WORDS (4),
        .AXI_ID     (4'd0)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .bus_arvalid (bus_arvalid),
        .bus_araddr  (bus_araddr),
        .bus_rready  (bus_rready),
        .bus_rdata   (bus_rdata),
        .bus_rvalid  (bus_rvalid),
        .bus_rlast   (bus_rlast),
        .axi_arvalid (axi_arvalid),
        .axi_arready (axi_arready),
        .axi_araddr  (axi_araddr),
        .axi_arid    (axi_arid),
        .axi_arlen   (axi_arlen),
        .axi_arsize  (axi_arsize),
        .axi_arburst (axi_arburst),
        .axi_rvalid  (axi_rvalid),
        .axi_rready  (axi_rready),
        .axi_rdata   (axi_rdata),
        .axi_rresp   (axi_rresp),
        .axi_rlast   (axi_rlast),
        .rerr        (rerr)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        forever begin
            @(posedge clock);
            cyc++;
        end
    end

    // AXI slave model: data word = 0xA0 + address bits [5:2]
    int unsigned ar_delay = 0;
    int unsigned ar_wait;
    int unsigned beats_left;
    int          err_beat = -1;
    logic        slave_kill = 1'b1;
    logic [31:0] beat_addr;
    logic        s_arvalid, s_rready;
    logic [31:0] s_araddr;
    logic [7:0]  s_arlen;
    logic [8:0]  s_attr;
    logic [31:0] ar_addr_log[$];
    logic [7:0]  ar_len_log[$];
    logic [8:0]  ar_attr_log[$];

    initial begin : axi_responder
        axi_arready = 1'b0;
        axi_rvalid  = 1'b0;
        axi_rdata   = 32'h0;
        axi_rresp   = 2'b00;
        axi_rlast   = 1'b0;
        ar_wait     = 0;
        beats_left  = 0;
        beat_addr   = 32'h0;
        forever begin
            @(negedge clock);
            s_arvalid = axi_arvalid;
            s_rready  = axi_rready;
            s_araddr  = axi_araddr;
            s_arlen   = axi_arlen;
            s_attr    = {axi_arid, axi_arsize, axi_arburst};
            @(posedge clock);
            #1;
            if (slave_kill) begin
                axi_arready = 1'b0;
                axi_rvalid  = 1'b0;
                axi_rdata   = 32'h0;
                axi_rresp   = 2'b00;
                axi_rlast   = 1'b0;
                beats_left  = 0;
                ar_wait     = 0;
            end else begin
                if (axi_rvalid && s_rready && beats_left != 0) begin
                    beats_left--;
                    beat_addr += 32'd4;
                end
                if (axi_arready && s_arvalid) begin
                    ar_addr_log.push_back(s_araddr);
                    ar_len_log.push_back(s_arlen);
                    ar_attr_log.push_back(s_attr);
                    beats_left = int'(s_arlen) + 1;
                    beat_addr  = s_araddr;
                end
                axi_arready = 1'b0;
                if (axi_arvalid) begin
                    if (ar_wait >= ar_delay) axi_arready = 1'b1;
                    else ar_wait++;
                end else begin
                    ar_wait = 0;
                end
                axi_rvalid = (beats_left != 0);
                axi_rdata  = axi_rvalid ? (32'hA0 + {28'h0, beat_addr[5:2]}) : 32'h0;
                axi_rresp  = (axi_rvalid && err_beat == int'(beat_addr[3:2])) ? 2'b10 : 2'b00;
                axi_rlast  = (beats_left == 1);
            end
        end
    end

    // Bus-side beat log
    logic [31:0] mon_data[$];
    logic        mon_last[$];
    logic        mon_rerr[$];
    int unsigned last_cnt = 0;

    initial begin : bus_monitor
        forever begin
            @(negedge clock);
            if (bus_rvalid) begin
                mon_data.push_back(bus_rdata);
                mon_last.push_back(bus_rlast);
                mon_rerr.push_back(rerr);
                if (bus_rlast) last_cnt++;
            end
        end
    end

    task automatic clear_logs();
        mon_data.delete();
        mon_last.delete();
        mon_rerr.delete();
        ar_addr_log.delete();
        ar_len_log.delete();
        ar_attr_log.delete();
    endtask

    // Raise a request, wait for its accept, drop it, then check AR follows one cycle later.
    task automatic do_request(input logic [31:0] addr);
        bit got = 0;
        @(posedge clock);
        #1;
        bus_arvalid = 1'b1;
        bus_araddr  = addr;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clock);
            if (bus_rready === 1'b1) got = 1;
        end
        n_checks++;
        if (!got) begin
            $display("FAIL req_accept: bus_rready never seen for addr %h", addr);
            n_fail++;
        end
        @(posedge clock);
        #1;
        bus_arvalid = 1'b0;
        @(negedge clock);
        n_checks++;
        if (axi_arvalid !== 1'b1) begin
            $display("FAIL ar_latency: axi_arvalid=%b required 1 one cycle after accept",
                     axi_arvalid);
            n_fail++;
        end
    endtask

    task automatic wait_lines(input int unsigned target, input string tag);
        bit done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clock);
            #1;
            if (last_cnt >= target) done = 1;
        end
        n_checks++;
        if (!done) begin
            $display("FAIL %s_timeout: rlast count %0d required %0d", tag, last_cnt, target);
            n_fail++;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        bus_arvalid = 1'b1;
        bus_araddr  = 32'h3000_0000;
        #1;
        n_checks++;
        if ({bus_rready, bus_rvalid, bus_rlast, axi_arvalid, axi_rready, rerr} !== 6'b0) begin
            $display("FAIL reset_ctrl: got %b required 000000",
                     {bus_rready, bus_rvalid, bus_rlast, axi_arvalid, axi_rready, rerr});
            n_fail++;
        end
        n_checks++;
        if ({bus_rdata, axi_araddr, axi_arlen} !== 72'h0) begin
            $display("FAIL reset_data: rdata=%h araddr=%h arlen=%h required 0",
                     bus_rdata, axi_araddr, axi_arlen);
            n_fail++;
        end
        n_checks++;
        if ({axi_arid, axi_arsize, axi_arburst} !== ExpAttr) begin
            $display("FAIL reset_const: got %b required %b",
                     {axi_arid, axi_arsize, axi_arburst}, ExpAttr);
            n_fail++;
        end
        bus_arvalid = 1'b0;
        @(negedge clock);
        reset      = 1'b1;
        slave_kill = 1'b0;
        @(negedge clock);
        n_checks++;
        if ({bus_rready, bus_rvalid, axi_arvalid, axi_rready, rerr} !== 5'b0) begin
            $display("FAIL idle_ctrl: got %b required 00000",
                     {bus_rready, bus_rvalid, axi_arvalid, axi_rready, rerr});
            n_fail++;
        end
    endtask

    task automatic test_line_fetch();
        int unsigned base = last_cnt;
        clear_logs();
        do_request(32'h3000_0008);
        wait_lines(base + 1, "fetch");
        n_checks++;
        if (ar_addr_log.size() != ExpArs) begin
            $display("FAIL fetch_ar_count: got %0d required %0d", ar_addr_log.size(), ExpArs);
            n_fail++;
        end
        for (int i = 0; i < ar_addr_log.size(); i++) begin
            n_checks++;
            if (ar_addr_log[i] !== 32'h3000_0000 + 32'(ExpArStep * i) ||
                ar_len_log[i] !== ExpLen || ar_attr_log[i] !== ExpAttr) begin
                $display("FAIL fetch_ar%0d: addr=%h len=%h attr=%b required %h %h %b", i,
                         ar_addr_log[i], ar_len_log[i], ar_attr_log[i],
                         32'h3000_0000 + 32'(ExpArStep * i), ExpLen, ExpAttr);
                n_fail++;
            end
        end
        n_checks++;
        if (mon_data.size() != 4) begin
            $display("FAIL fetch_beats: got %0d required 4", mon_data.size());
            n_fail++;
        end
        for (int i = 0; i < mon_data.size() && i < 4; i++) begin
            n_checks++;
            if (mon_data[i] !== 32'hA0 + 32'(i) || mon_last[i] !== (i == 3) ||
                mon_rerr[i] !== 1'b0) begin
                $display("FAIL fetch_beat%0d: data=%h last=%b rerr=%b required %h %b 0", i,
                         mon_data[i], mon_last[i], mon_rerr[i], 32'hA0 + 32'(i), (i == 3));
                n_fail++;
            end
        end
    endtask

    task automatic test_arready_stall();
        int unsigned base = last_cnt;
        int unsigned stall = 0;
        int unsigned bad = 0;
        int unsigned early = 0;
        bit hs = 0;
        clear_logs();
        ar_delay = 5;
        do_request(32'h3000_0040);
        for (int i = 0; i < 30 && !hs; i++) begin
            if (i > 0) @(negedge clock);
            if (bus_rvalid === 1'b1) early++;
            if (axi_arvalid === 1'b1) begin
                if (axi_araddr !== 32'h3000_0040 || axi_arlen !== ExpLen) bad++;
                if (axi_arready) hs = 1;
                else stall++;
            end
        end
        n_checks++;
        if (!hs || stall != 5) begin
            $display("FAIL stall_cycles: handshake=%0d stalled=%0d required 1 and 5", hs, stall);
            n_fail++;
        end
        n_checks++;
        if (bad != 0) begin
            $display("FAIL stall_stable: %0d unstable cycles required 0", bad);
            n_fail++;
        end
        n_checks++;
        if (early != 0) begin
            $display("FAIL stall_early_rvalid: %0d beats before handshake required 0", early);
            n_fail++;
        end
        wait_lines(base + 1, "stall");
        ar_delay = 0;
        n_checks++;
        if (mon_data.size() != 4) begin
            $display("FAIL stall_beats: got %0d required 4", mon_data.size());
            n_fail++;
        end
        for (int i = 0; i < mon_data.size() && i < 4; i++) begin
            n_checks++;
            if (mon_data[i] !== 32'hA0 + 32'(i) || mon_last[i] !== (i == 3)) begin
                $display("FAIL stall_beat%0d: data=%h last=%b required %h %b", i,
                         mon_data[i], mon_last[i], 32'hA0 + 32'(i), (i == 3));
                n_fail++;
            end
        end
    endtask

    task automatic test_back_to_back();
        int unsigned base = last_cnt;
        int unsigned acc = 0;
        int unsigned acc2_cyc = 0;
        int unsigned last_cyc = 0;
        int unsigned bad = 0;
        clear_logs();
        @(posedge clock);
        #1;
        bus_arvalid = 1'b1;
        bus_araddr  = 32'h3000_0080;
        for (int i = 0; i < 200 && acc < 2; i++) begin
            @(negedge clock);
            if (bus_rready === 1'b1) begin
                acc++;
                if (acc == 2) acc2_cyc = cyc;
                if (axi_arvalid || axi_rready) bad++;
            end
            if (bus_rlast === 1'b1 && acc == 1) last_cyc = cyc;
        end
        @(posedge clock);
        #1;
        bus_arvalid = 1'b0;
        n_checks++;
        if (acc != 2 || acc2_cyc != last_cyc + 1) begin
            $display("FAIL b2b_accept: accepts=%0d second at %0d required 2 at %0d",
                     acc, acc2_cyc, last_cyc + 1);
            n_fail++;
        end
        n_checks++;
        if (bad != 0) begin
            $display("FAIL b2b_busy_rready: %0d accepts while busy required 0", bad);
            n_fail++;
        end
        wait_lines(base + 2, "b2b");
        n_checks++;
        if (mon_data.size() != 8) begin
            $display("FAIL b2b_beats: got %0d required 8", mon_data.size());
            n_fail++;
        end
        for (int i = 0; i < mon_data.size() && i < 8; i++) begin
            n_checks++;
            if (mon_data[i] !== 32'hA0 + 32'(i % 4) || mon_last[i] !== ((i % 4) == 3)) begin
                $display("FAIL b2b_beat%0d: data=%h last=%b required %h %b", i,
                         mon_data[i], mon_last[i], 32'hA0 + 32'(i % 4), ((i % 4) == 3));
                n_fail++;
            end
        end
    endtask

    task automatic test_rerr();
        int unsigned base = last_cnt;
        logic [3:0] exp_rerr = 4'b1100;  // bit i = beat i
        clear_logs();
        err_beat = 2;
        do_request(32'h3000_00C0);
        wait_lines(base + 1, "rerr");
        err_beat = -1;
        n_checks++;
        if (mon_rerr.size() != 4) begin
            $display("FAIL rerr_beats: got %0d required 4", mon_rerr.size());
            n_fail++;
        end
        for (int i = 0; i < mon_rerr.size() && i < 4; i++) begin
            n_checks++;
            if (mon_rerr[i] !== exp_rerr[i] || mon_data[i] !== 32'hA0 + 32'(i)) begin
                $display("FAIL rerr_beat%0d: rerr=%b data=%h required %b %h", i,
                         mon_rerr[i], mon_data[i], exp_rerr[i], 32'hA0 + 32'(i));
                n_fail++;
            end
        end
        @(negedge clock);
        n_checks++;
        if (rerr !== 1'b1) begin
            $display("FAIL rerr_sticky: rerr=%b required 1 after line end", rerr);
            n_fail++;
        end
        clear_logs();
        do_request(32'h3000_00C0);
        n_checks++;
        if (rerr !== 1'b0) begin
            $display("FAIL rerr_clear: rerr=%b required 0 after accept", rerr);
            n_fail++;
        end
        wait_lines(base + 2, "rerr2");
        for (int i = 0; i < mon_rerr.size() && i < 4; i++) begin
            n_checks++;
            if (mon_rerr[i] !== 1'b0) begin
                $display("FAIL rerr_clean%0d: rerr=%b required 0", i, mon_rerr[i]);
                n_fail++;
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        int unsigned base = last_cnt;
        bit got = 0;
        clear_logs();
        do_request(32'h3000_0100);
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clock);
            #1;
            if (mon_data.size() >= 2) got = 1;
        end
        n_checks++;
        if (!got) begin
            $display("FAIL midrst_beat1: beats=%0d required 2", mon_data.size());
            n_fail++;
        end
        #1;
        reset      = 1'b0;
        slave_kill = 1'b1;
        #1;
        n_checks++;
        if ({bus_rready, bus_rvalid, bus_rlast, axi_arvalid, axi_rready, rerr} !== 6'b0) begin
            $display("FAIL midrst_ctrl: got %b required 000000",
                     {bus_rready, bus_rvalid, bus_rlast, axi_arvalid, axi_rready, rerr});
            n_fail++;
        end
        n_checks++;
        if ({bus_rdata, axi_araddr, axi_arlen} !== 72'h0) begin
            $display("FAIL midrst_data: rdata=%h araddr=%h arlen=%h required 0",
                     bus_rdata, axi_araddr, axi_arlen);
            n_fail++;
        end
        repeat (2) @(negedge clock);
        reset      = 1'b1;
        slave_kill = 1'b0;
        n_checks++;
        if (mon_data.size() != 2) begin
            $display("FAIL midrst_drain: beats=%0d required 2", mon_data.size());
            n_fail++;
        end
        clear_logs();
        do_request(32'h3000_0100);
        wait_lines(base + 1, "midrst");
        n_checks++;
        if (mon_data.size() != 4) begin
            $display("FAIL midrst_refetch: beats=%0d required 4", mon_data.size());
            n_fail++;
        end
        for (int i = 0; i < mon_data.size() && i < 4; i++) begin
            n_checks++;
            if (mon_data[i] !== 32'hA0 + 32'(i) || mon_last[i] !== (i == 3)) begin
                $display("FAIL midrst_beat%0d: data=%h last=%b required %h %b", i,
                         mon_data[i], mon_last[i], 32'hA0 + 32'(i), (i == 3));
                n_fail++;
            end
        end
    endtask

    initial begin
        reset       = 1'b0;
        bus_arvalid = 1'b0;
        bus_araddr  = 32'h0;
        test_reset();
        test_line_fetch();
        test_arready_stall();
        test_back_to_back();
        test_rerr();
        test_reset_mid_burst();
        repeat (3) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
